// File: rtl/uart_frame_pkg.sv
// Shared constants, state encoding and expected-byte helpers for the
// voltage telemetry line parser ("Vcc - dddd V" LF CR).
package uart_frame_pkg;

    localparam logic [7:0] ASC_V    = 8'h56;
    localparam logic [7:0] ASC_SP   = 8'h20;
    localparam logic [7:0] ASC_DASH = 8'h2D;
    localparam logic [7:0] ASC_LF   = 8'h0A;
    localparam logic [7:0] ASC_CR   = 8'h0D;
    localparam logic [7:0] ASC_0    = 8'h30;
    localparam logic [7:0] ASC_9    = 8'h39;

    localparam int CHAN_LEN = 2;
    localparam int SEP_LEN  = 3;
    localparam int DATA_LEN = 4;
    localparam int TAIL_LEN = 4;

    typedef enum logic [4:0] {
        ST_HUNT = 5'b00001,
        ST_CHAN = 5'b00010,
        ST_SEP  = 5'b00100,
        ST_DATA = 5'b01000,
        ST_TAIL = 5'b10000
    } parse_state_t;

    // Separator is " - ": only the middle byte differs.
    function automatic logic [7:0] sep_byte(input logic [1:0] idx);
        return (idx == 2'd1) ? ASC_DASH : ASC_SP;
    endfunction

    function automatic logic [7:0] tail_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return ASC_SP;
            2'd1:    return ASC_V;
            2'd2:    return ASC_LF;
            default: return ASC_CR;
        endcase
    endfunction

endpackage

// File: rtl/uart_ascii_digit.sv
// Combinational ASCII decimal digit decoder: flags '0'..'9' and yields its value.
module uart_ascii_digit
    import uart_frame_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic       is_digit,
    output logic [3:0] nibble
);

    assign is_digit = (byte_in >= ASC_0) && (byte_in <= ASC_9);
    assign nibble   = byte_in[3:0];

endmodule

// File: rtl/uart_line_parser.sv
// Receive-side parser for "Vcc - dddd V" LF CR telemetry lines.
// Optional statistics counters enabled by defining UART_PARSER_STATS_EN.
module uart_line_parser
    import uart_frame_pkg::*;
#(
    parameter int NUM_CH         = 13,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TO_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_tick,
    output logic [3:0]  ch_idx,
    output logic [15:0] ch_value,
    output logic        valid,
    output logic        frame_err
`ifdef UART_PARSER_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    parse_state_t    state;
    logic [1:0]      idx;
    logic [3:0]      chan_hi;
    logic [3:0]      chan_lo;
    logic [15:0]     val_sh;
    logic [TO_W-1:0] to_cnt;

    logic       is_digit;
    logic [3:0] nibble;
    logic       byte_ok;
    logic       seg_end;
    logic [6:0] field;
    logic       chan_ok;

    uart_ascii_digit u_digit (
        .byte_in  (rx_data),
        .is_digit (is_digit),
        .nibble   (nibble)
    );

    always_comb begin
        byte_ok = 1'b0;
        seg_end = 1'b0;
        case (state)
            ST_CHAN: begin
                byte_ok = is_digit;
                seg_end = (idx == 2'(CHAN_LEN - 1));
            end
            ST_SEP: begin
                byte_ok = (rx_data == sep_byte(idx));
                seg_end = (idx == 2'(SEP_LEN - 1));
            end
            ST_DATA: begin
                byte_ok = is_digit;
                seg_end = (idx == 2'(DATA_LEN - 1));
            end
            ST_TAIL: begin
                byte_ok = (rx_data == tail_byte(idx));
                seg_end = (idx == 2'(TAIL_LEN - 1));
            end
            default: begin
                byte_ok = 1'b0;
                seg_end = 1'b0;
            end
        endcase
    end

    assign field   = 7'(chan_hi) * 7'd10 + 7'(chan_lo);
    assign chan_ok = (field >= 7'd1) && (field <= 7'(NUM_CH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HUNT;
            idx       <= 2'd0;
            chan_hi   <= 4'd0;
            chan_lo   <= 4'd0;
            val_sh    <= 16'd0;
            to_cnt    <= '0;
            ch_idx    <= 4'd0;
            ch_value  <= 16'd0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (rx_tick) begin
                // A byte arriving on the expiry cycle still counts as activity.
                to_cnt <= '0;
                if (state != ST_HUNT && !byte_ok) begin
                    frame_err <= 1'b1;
                    idx       <= 2'd0;
                    state     <= (rx_data == ASC_V) ? ST_CHAN : ST_HUNT;
                end else begin
                    idx <= seg_end ? 2'd0 : idx + 2'd1;
                    case (state)
                        ST_HUNT: begin
                            idx <= 2'd0;
                            if (rx_data == ASC_V) state <= ST_CHAN;
                        end
                        ST_CHAN: begin
                            if (idx == 2'd0) chan_hi <= nibble;
                            else             chan_lo <= nibble;
                            if (seg_end) state <= ST_SEP;
                        end
                        ST_SEP: begin
                            if (seg_end) state <= ST_DATA;
                        end
                        ST_DATA: begin
                            // Shifting in MSD first leaves d3 in [15:12] after four digits.
                            val_sh <= {val_sh[11:0], nibble};
                            if (seg_end) state <= ST_TAIL;
                        end
                        ST_TAIL: begin
                            if (seg_end) begin
                                state <= ST_HUNT;
                                if (chan_ok) begin
                                    ch_idx   <= 4'(field - 7'd1);
                                    ch_value <= val_sh;
                                    valid    <= 1'b1;
                                end else begin
                                    frame_err <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            state <= ST_HUNT;
                            idx   <= 2'd0;
                        end
                    endcase
                end
            end else if (state == ST_HUNT) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                to_cnt    <= '0;
                frame_err <= 1'b1;
                state     <= ST_HUNT;
                idx       <= 2'd0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

`ifdef UART_PARSER_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 16'd0;
            err_cnt   <= 16'd0;
        end else begin
            if (valid)     frame_cnt <= sat_inc(frame_cnt);
            if (frame_err) err_cnt   <= sat_inc(err_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_uart_line_parser.sv
// Scoreboard bench for uart_line_parser: expected line results are queued as
// bytes are driven and compared when valid/frame_err pulses.
module tb_uart_line_parser;

    localparam int TO_CYC = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_tick;
    logic [3:0]  ch_idx;
    logic [15:0] ch_value;
    logic        valid;
    logic        frame_err;

    uart_line_parser #(
        .NUM_CH         (13),
        .TIMEOUT_CYCLES (TO_CYC),
        .TO_W           (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_tick   (rx_tick),
        .ch_idx    (ch_idx),
        .ch_value  (ch_value),
        .valid     (valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        bit          lat;
        logic [3:0]  idx;
        logic [15:0] val;
    } exp_t;

    exp_t        sbq[$];
    exp_t        ev;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          tick_cyc = 0;
    logic [3:0]  cur_idx  = 4'd0;
    logic [15:0] cur_val  = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_tick = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic push_ok(input logic [3:0] i, input logic [15:0] v);
        cur_idx = i;
        cur_val = v;
        sbq.push_back('{err: 1'b0, lat: 1'b1, idx: i, val: v});
    endtask

    task automatic push_err(input bit lat);
        sbq.push_back('{err: 1'b1, lat: lat, idx: cur_idx, val: cur_val});
    endtask

    always @(posedge clk) begin
        if (rx_tick) tick_cyc <= cyc;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst && (valid || frame_err)) begin
            check("exclusive", 32'(valid & frame_err), 32'd0);
            if (sbq.size() == 0) begin
                check("unexpected_evt", 32'(frame_err), 32'd2);
            end else begin
                ev = sbq.pop_front();
                check("evt_kind", 32'(frame_err), 32'(ev.err));
                check("ch_idx", 32'(ch_idx), 32'(ev.idx));
                check("ch_value", 32'(ch_value), 32'(ev.val));
                if (ev.lat) check("latency", 32'(cyc - tick_cyc), 32'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog sim_time_exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst     = 1'b1;
        rx_tick = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ch_idx", 32'(ch_idx), 32'd0);
        check("rst_ch_value", 32'(ch_value), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1 and 2, sent back to back with no idle cycles
        push_ok(4'd0, 16'h1234);
        send_str("V01 - 1234 V"); send_byte(8'h0A); send_byte(8'h0D);
        push_ok(4'd12, 16'h0987);
        send_str("V13 - 0987 V"); send_byte(8'h0A); send_byte(8'h0D);
        push_err(1'b1);
        send_str("V00 - 0001 V"); send_byte(8'h0A); send_byte(8'h0D);
        repeat (3) @(negedge clk);
        check("hold_idx", 32'(ch_idx), 32'd12);
        check("hold_val", 32'(ch_value), 32'h0987);

        // 3: resync on 'V' inside the data field
        push_err(1'b1);
        push_ok(4'd6, 16'h4321);
        send_str("V05 - 12V07 - 4321 V"); send_byte(8'h0A); send_byte(8'h0D);
        repeat (3) @(negedge clk);

        // 4: timeout mid-frame
        push_err(1'b0);
        send_str("V03 - 55");
        n = 0;
        for (int i = 0; i < TO_CYC + 10; i++) begin
            @(negedge clk);
            n++;
            if (frame_err) break;
        end
        check("timeout_lat", 32'((n >= TO_CYC) && (n <= TO_CYC + 1)), 32'd1);
        @(negedge clk);
        push_ok(4'd10, 16'h5678);
        send_str("V11 - 5678 V"); send_byte(8'h0A); send_byte(8'h0D);
        repeat (3) @(negedge clk);

        // 5: garbage dropped, swapped CR/LF rejected
        send_byte(8'hFF); send_byte(8'h41);
        push_err(1'b1);
        send_str("V02 - 0000 V"); send_byte(8'h0D); send_byte(8'h0A);
        repeat (3) @(negedge clk);
        check("swap_hold_idx", 32'(ch_idx), 32'd10);
        check("swap_hold_val", 32'(ch_value), 32'h5678);

        // 6: reset mid-frame
        send_str("V04 - 1");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_idx", 32'(ch_idx), 32'd0);
        check("mid_rst_val", 32'(ch_value), 32'd0);
        check("mid_rst_flags", 32'({valid, frame_err}), 32'd0);
        cur_idx = 4'd0;
        cur_val = 16'd0;
        rst = 1'b0;
        @(negedge clk);
        push_ok(4'd8, 16'h2468);
        send_str("V09 - 2468 V"); send_byte(8'h0A); send_byte(8'h0D);
        repeat (5) @(negedge clk);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
